// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - operation select encoding (OP_MULT / OP_DIV)
//   - helper for the width-derived iteration counter size
package multdiv_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // The counter must reach WIDTH itself: the iteration steps use values
    // 0..WIDTH-1, and the value WIDTH marks the result-writing cycle.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: operand/control/result bundle between the execute stage
// (master) and the multiply/divide unit (slave).
//   data_operandA/B   : operands, sampled on an accepted start
//   ctrl_MULT/ctrl_DIV: start strobes (multiply has priority)
//   data_result       : registered product low half or quotient
//   data_exception    : overflow / divide-by-zero flag, valid with ready
//   data_resultRDY    : one-cycle completion pulse
//   busy              : operation in progress, pipeline must stall
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_addsub_unit.sv
// addsub_unit: N-bit adder/subtractor shared by the multiply add step and
// the divide trial subtraction.
//   a, b : operands
//   sub  : 1 -> y = a - b, 0 -> y = a + b (modulo 2^N)
//   y    : result
module addsub_unit #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);
    logic [N-1:0] b_eff;

    // Two's-complement subtract: invert b and inject the +1 as carry-in.
    assign b_eff = b ^ {N{sub}};
    assign y     = a + b_eff + {{(N-1){1'b0}}, sub};
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply / divide, one radix-2 step per
// clock. Latency from the accepted start edge to the ready pulse is
// WIDTH+1 edges; back-to-back starts are accepted in the DONE cycle.
//   clock, reset : single clock, synchronous active-high reset
//   bus          : multdiv_if slave port (operands, strobes, result,
//                  exception, ready pulse, busy)
// WIDTH legal range is 4..64.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic             sign_q, sign_d;
    logic             divz_q, divz_d;
    logic             rdy_q, rdy_d;
    logic             exc_q, exc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // hi: upper product half / partial remainder
    // lo: multiplier then low product half / dividend then quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mag_q, mag_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] result_q, result_d;

    // Operand magnitudes are formed one bit wider so that the most-negative
    // value maps to 2^(WIDTH-1) instead of wrapping; that value then fits
    // in WIDTH unsigned bits.
    logic             start;
    logic [WIDTH:0]   a_ext, b_ext, a_abs, b_abs;
    logic             unused_abs_msb;

    assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
    assign a_ext    = {bus.data_operandA[WIDTH-1], bus.data_operandA};
    assign b_ext    = {bus.data_operandB[WIDTH-1], bus.data_operandB};
    assign a_abs    = a_ext[WIDTH] ? -a_ext : a_ext;
    assign b_abs    = b_ext[WIDTH] ? -b_ext : b_ext;
    assign unused_abs_msb = a_abs[WIDTH] ^ b_abs[WIDTH];

    // Shared WIDTH+1-bit datapath adder.
    logic [WIDTH:0] as_a, as_b, as_y;
    logic           as_sub;

    always_comb begin
        as_sub = (op_q == OP_DIV);
        as_b   = {1'b0, mag_q};
        if (as_sub) begin
            // Trial subtract: remainder shifted left with next dividend bit.
            as_a = {hi_q, lo_q[WIDTH-1]};
        end else begin
            as_a = {1'b0, hi_q};
        end
    end

    addsub_unit #(
        .N(WIDTH + 1)
    ) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .y   (as_y)
    );

    // Multiply step: add multiplicand when the current multiplier bit is set,
    // carry bit included, then shift the whole accumulator right by one.
    logic [WIDTH:0] mul_step;
    assign mul_step = lo_q[0] ? as_y : {1'b0, hi_q};

    // Completion values.
    logic [2*WIDTH-1:0] prod_mag, prod_signed;
    logic [WIDTH:0]     prod_top;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quot_signed;
    logic               div_ovf;

    assign prod_mag    = {hi_q, lo_q};
    assign prod_signed = sign_q ? -prod_mag : prod_mag;
    // Fits in WIDTH signed bits iff the bits above the result sign bit are
    // copies of it.
    assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
    assign mul_ovf     = !((prod_top == '0) || (prod_top == '1));
    assign quot_signed = sign_q ? -lo_q : lo_q;
    // A positive quotient of 2^(WIDTH-1) only arises from MIN / -1.
    assign div_ovf     = !sign_q && lo_q[WIDTH-1];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        divz_d   = divz_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mag_d    = mag_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = bus.ctrl_MULT ? OP_MULT : OP_DIV;
                    sign_d  = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                    divz_d  = (bus.data_operandB == '0);
                    cnt_d   = '0;
                    hi_d    = '0;
                    if (bus.ctrl_MULT) begin
                        lo_d  = b_abs[WIDTH-1:0];
                        mag_d = a_abs[WIDTH-1:0];
                    end else begin
                        lo_d  = a_abs[WIDTH-1:0];
                        mag_d = b_abs[WIDTH-1:0];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                    if (op_q == OP_MULT) begin
                        result_d = prod_signed[WIDTH-1:0];
                        exc_d    = mul_ovf;
                    end else if (divz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = quot_signed;
                        exc_d    = div_ovf;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (op_q == OP_MULT) begin
                        hi_d = mul_step[WIDTH:1];
                        lo_d = {mul_step[0], lo_q[WIDTH-1:1]};
                    end else begin
                        // Restore (keep shifted remainder) when the trial
                        // subtraction went negative.
                        hi_d = as_y[WIDTH] ? as_a[WIDTH-1:0] : as_y[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], ~as_y[WIDTH]};
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            sign_q   <= 1'b0;
            divz_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mag_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            divz_q   <= divz_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mag_q    <= mag_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = (state_q == ST_RUN);

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Parametrised multi-cycle signed multiply/divide unit, the iterative companion to the single-cycle add/subtract ALU in the execute stage. One operation is accepted per start pulse. The datapath performs one shift-add or shift-subtract step per clock and returns a registered result with a one-cycle ready pulse and an exception flag. The processor stalls on `busy` and writes back on `data_resultRDY`.

## Interface
- `WIDTH`, 32: operand/result width in bits, two's complement; legal range 4..64.
- `clock`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the sampled edge.
- `data_operandA`  in  WIDTH  multiplicand / dividend; sampled only on an accepted start.
- `data_operandB`  in  WIDTH  multiplier / divisor; sampled only on an accepted start.
- `ctrl_MULT`  in  1  start signed multiply (level sampled each edge).
- `ctrl_DIV`  in  1  start signed divide.
- `data_result`  out  WIDTH  low WIDTH bits of product, or quotient; registered.
- `data_exception`  out  1  error flag for the completed operation; valid with `data_resultRDY`.
- `data_resultRDY`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the accepted-start edge until the edge that raises `data_resultRDY`.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: a start is accepted if `ctrl_MULT` or `ctrl_DIV` is high. On acceptance, latch the op and operand magnitudes, record the result sign, clear the iteration counter, and go to RUN.
  - RUN: one iteration per cycle. After WIDTH iterations, write `data_result`/`data_exception`, go to DONE.
  - DONE: `data_resultRDY`=1 for this cycle only. The next state is IDLE, or RUN if a new start is sampled in this cycle (back-to-back operations are allowed).
- Both `ctrl_MULT` and `ctrl_DIV` high on acceptance: multiply wins.
- Start pulses while in RUN are ignored (not queued).
- Multiply:
  - Unsigned radix-2 shift-add on magnitudes into a 2·WIDTH accumulator.
  - Apply the sign at completion.
  - `data_exception`=1 if the signed 2·WIDTH product does not fit in WIDTH bits. `data_result` is still the low WIDTH bits.
- Divide:
  - Restoring division on magnitudes. The quotient truncates toward zero; the remainder is discarded.
  - Divisor 0: `data_result`=0, `data_exception`=1. Latency is unchanged; the unit still runs WIDTH iterations.
  - Most-negative value ÷ −1: `data_result`=most-negative value, `data_exception`=1.
- Magnitude of the most-negative operand is handled with WIDTH+1-bit internal arithmetic. No wrap is allowed.

## Timing
- Reset values: state IDLE, `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
- Start sampled at edge E, where E is the first edge at which `ctrl_MULT`/`ctrl_DIV` is high in IDLE or DONE.
  - `busy`=1 after E.
  - `data_resultRDY`=1 and the result is valid during the cycle after edge E+WIDTH+1 (latency WIDTH+1 edges). For WIDTH=32, latency is 33.
- `busy` drops at the same edge that raises `data_resultRDY`.
- `data_result` and `data_exception` hold their values until the next completion. They do not change during RUN.
- Operands may change freely after E.
- Reset asserted mid-RUN or in DONE: the operation is aborted at that edge, all outputs go to reset values, and no ready pulse is produced.
- Start high in the same cycle as `reset`: ignored.

## Structure
- Package `multdiv_pkg` holds:
  - state enum (IDLE/RUN/DONE)
  - op-select constants (OP_MULT, OP_DIV)
  - width-derived localparams (counter width = $clog2(WIDTH+1))
- Sub-module `addsub_unit`: a WIDTH+1-bit adder/subtractor with a subtract control. It is shared by the multiply add step and the divide trial subtract. The top holds the FSM, counter, shift registers and sign/exception logic.

## Test plan
- WIDTH=32, MULT 7 × −6 → `data_result`=−42 (0xFFFFFFD6), exception 0, ready exactly 33 edges after start, single-cycle pulse.
- MULT 0x00010000 × 0x00010000 → `data_result`=0, exception 1. MULT 0x80000000 × 1 → 0x80000000, exception 0.
- DIV −7 ÷ 2 → −3, exception 0. DIV 100 ÷ 0 → 0, exception 1, same 33-cycle latency. DIV 0x80000000 ÷ −1 → 0x80000000, exception 1.
- Start held high continuously for 3 operations → results every 34 cycles, back-to-back via DONE→RUN. Stray `ctrl_DIV` pulses during RUN have no effect.
- Reset at iteration 10 of a multiply → outputs zero next cycle, no `data_resultRDY`. A new DIV 9 ÷ 3 afterwards returns 3.
- Both starts high (A=6, B=3) → product 18 returned. WIDTH=8 instance: MULT −128 × −1 → exception 1, DIV −128 ÷ 3 → −42, latency 9.
